// File: rtl/rv_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : rv_regfile_pkg
//  Purpose   : Shared types and constants for the register-file arbiter:
//              arbiter state encoding, default widths and the x0 index.
//  Revision  : 1.0  initial release
// ============================================================================
package rv_regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  // Architectural zero register: writes are dropped, reads return 0.
  localparam int REG_X0 = 0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } arb_state_e;

endpackage : rv_regfile_pkg
`default_nettype wire

// File: rtl/rf_starve_cnt.sv
`default_nettype none
// ============================================================================
//  Module    : rf_starve_cnt
//  Purpose   : Saturating count of consecutive cycles the debug unit was
//              denied. Flags when the count has reached LIMIT.
//  Ports     : clk      in  clock
//              rst      in  asynchronous reset, active-low
//              inc      in  debug requested and was denied this cycle
//              clr      in  debug granted or not requesting this cycle
//              at_limit out count equals LIMIT
//  Revision  : 1.0  initial release
// ============================================================================
module rf_starve_cnt #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != C_LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_limit = (cnt == C_LIMIT);

endmodule : rf_starve_cnt
`default_nettype wire

// File: rtl/regfile_arbiter.sv
`default_nettype none
// ============================================================================
//  Module    : regfile_arbiter
//  Purpose   : Shares one read-pair port and one write port of the register
//              file between the core datapath and the debug unit. Drives all
//              regfile controls, registers read data into 1-cycle responses,
//              forwards same-cycle writes, and sequences debug halt/resume.
//  Ports     : clk, rst                      clock, async active-low reset
//              core_rd_req/rs1/rs2/rs1_v/rs2_v  core read request
//              core_rd_gnt                   core read granted (comb)
//              core_wr_req/rd/wdata, core_wr_gnt  core writeback
//              core_rsp_v, core_rs1/rs2_data registered core read response
//              dbg_req/we/addr/wdata, dbg_gnt debug access
//              dbg_rsp_v, dbg_rdata          registered debug read response
//              dbg_halt_req, dbg_halted      halt handshake
//              rf_*                          regfile control / data pins
//  Revision  : 1.0  initial release
// ============================================================================
module regfile_arbiter
  import rv_regfile_pkg::*;
#(
  parameter int DATA_W       = RF_DATA_W,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_rd_req,
  input  logic [ADDR_W-1:0] core_rs1,
  input  logic [ADDR_W-1:0] core_rs2,
  input  logic              core_rs1_v,
  input  logic              core_rs2_v,
  output logic              core_rd_gnt,
  input  logic              core_wr_req,
  input  logic [ADDR_W-1:0] core_rd,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_wr_gnt,
  output logic              core_rsp_v,
  output logic [DATA_W-1:0] core_rs1_data,
  output logic [DATA_W-1:0] core_rs2_data,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rsp_v,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_halt_req,
  output logic              dbg_halted,
  output logic              rf_read_en,
  output logic              rf_write_en,
  output logic              rf_rs1_v,
  output logic              rf_rs2_v,
  output logic              rf_rd_v,
  output logic [ADDR_W-1:0] rf_rs1,
  output logic [ADDR_W-1:0] rf_rs2,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_rd_data,
  input  logic [DATA_W-1:0] rf_rs1_data,
  input  logic [DATA_W-1:0] rf_rs2_data
);

  localparam logic [ADDR_W-1:0] C_X0 = ADDR_W'(REG_X0);

  arb_state_e state, state_nxt;

  logic              starve_hit;
  logic              core_ok, dbg_prio;
  logic              dbg_rd_gnt, dbg_wr_gnt;
  logic              wr_any, wr_live;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rs1_val, rs2_val;

  // --------------------------------------------------------------------------
  // Starvation tracking
  // --------------------------------------------------------------------------
  rf_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (dbg_req & ~dbg_gnt),
    .clr      (dbg_gnt | ~dbg_req),
    .at_limit (starve_hit)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM: next state. Core grants stop once DRAIN is entered, so the only
  // response that can still be outstanding is the pulse of the last RUN
  // grant, which issues during the single DRAIN cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (dbg_halt_req)  state_nxt = DRAIN;
      DRAIN:   state_nxt = dbg_halt_req ? HALTED : RUN;
      HALTED:  if (!dbg_halt_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (grants). Everything is qualified with rst so that all
  // outputs read 0 while reset is held, regardless of requests.
  // --------------------------------------------------------------------------
  always_comb begin
    core_ok     = rst && (state == RUN);
    dbg_prio    = (state != RUN) || starve_hit;
    dbg_rd_gnt  = rst && dbg_req && !dbg_we &&
                  (!(core_ok && core_rd_req) || dbg_prio);
    dbg_wr_gnt  = rst && dbg_req && dbg_we &&
                  (!(core_ok && core_wr_req) || dbg_prio);
    core_rd_gnt = core_ok && core_rd_req && !dbg_rd_gnt;
    core_wr_gnt = core_ok && core_wr_req && !dbg_wr_gnt;
    dbg_gnt     = dbg_rd_gnt || dbg_wr_gnt;
    dbg_halted  = rst && (state == HALTED);
  end

  // --------------------------------------------------------------------------
  // Regfile pin muxing
  // --------------------------------------------------------------------------
  always_comb begin
    wr_any  = core_wr_gnt || dbg_wr_gnt;
    wr_idx  = core_wr_gnt ? core_rd    : dbg_addr;
    wr_data = core_wr_gnt ? core_wdata : dbg_wdata;
    // A granted write to x0 completes but never touches the array.
    wr_live = wr_any && (wr_idx != C_X0);

    rf_read_en  = core_rd_gnt || dbg_rd_gnt;
    rf_rs1      = core_rd_gnt ? core_rs1 : (dbg_rd_gnt ? dbg_addr : '0);
    rf_rs2      = core_rd_gnt ? core_rs2 : '0;
    rf_rs1_v    = core_rd_gnt ? core_rs1_v : dbg_rd_gnt;
    rf_rs2_v    = core_rd_gnt && core_rs2_v;
    rf_write_en = wr_live;
    rf_rd_v     = wr_live;
    rf_rd       = wr_live ? wr_idx  : '0;
    rf_rd_data  = wr_live ? wr_data : '0;

    // Read-value resolution: x0 reads as zero, then same-cycle write wins.
    if (rf_rs1 == C_X0)                   rs1_val = '0;
    else if (wr_live && rf_rs1 == wr_idx) rs1_val = wr_data;
    else                                  rs1_val = rf_rs1_data;

    if (rf_rs2 == C_X0)                   rs2_val = '0;
    else if (wr_live && rf_rs2 == wr_idx) rs2_val = wr_data;
    else                                  rs2_val = rf_rs2_data;
  end

  // --------------------------------------------------------------------------
  // Registered responses. Reset clears any response in flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rsp_v    <= 1'b0;
      core_rs1_data <= '0;
      core_rs2_data <= '0;
      dbg_rsp_v     <= 1'b0;
      dbg_rdata     <= '0;
    end else begin
      core_rsp_v <= core_rd_gnt;
      dbg_rsp_v  <= dbg_rd_gnt;
      if (core_rd_gnt) begin
        core_rs1_data <= rs1_val;
        core_rs2_data <= rs2_val;
      end
      if (dbg_rd_gnt) begin
        dbg_rdata <= rs1_val;
      end
    end
  end

endmodule : regfile_arbiter
`default_nettype wire
